// File: rtl/dmem_responder_if.sv
// dmem_responder_if: processor load/store bus plus the TX stream toward the downstream consumer.
interface dmem_responder_if;
  logic        WE;
  logic [31:0] address_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  modport master (
    output WE, address_to_mem, data_to_mem, tx_ready,
    input  data_from_mem, tx_valid, tx_data
  );
  modport slave (
    input  WE, address_to_mem, data_to_mem, tx_ready,
    output data_from_mem, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus memory-mapped TX FIFO, STATUS and store counter.
// Defining DMEM_STORE_TRACE_EN prints every accepted RAM/TXDATA store.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input logic            clk,
  input logic            reset_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0]   ram_q  [DEPTH_WORDS];
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   stcnt_q, stcnt_d;
  logic [31:0]   a, status, rdata;
  logic [AW-1:0] idx;
  logic          is_ram, is_tx, is_st, is_sc, ram_we, full, pop, push;
  // low address bits are folded in with |3 so every register decode ignores them
  always_comb begin
    a       = bus.address_to_mem;
    idx     = a[AW+1:2];
    is_ram  = (a >> (AW + 2)) == '0;
    is_tx   = (a | 32'd3) == 32'hFFFF_0003;
    is_st   = (a | 32'd3) == 32'hFFFF_0007;
    is_sc   = (a | 32'd3) == 32'hFFFF_000B;
    ram_we  = bus.WE & is_ram;
    full    = cnt_q == (PW+1)'(FIFO_DEPTH);
    pop     = (cnt_q != '0) & bus.tx_ready;
    push    = bus.WE & is_tx & (~full | pop);
    status  = 32'(cnt_q) | {25'b0, ovf_q, full, 5'b0};
    rdata   = is_ram ? ram_q[idx] : is_st ? status : is_sc ? stcnt_q : '0;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    stcnt_d = stcnt_q + 32'(ram_we);
    ovf_d   = (bus.WE & is_tx & full & ~pop) | (ovf_q & ~(bus.WE & is_st & bus.data_to_mem[6]));
  end
  assign bus.data_from_mem = rdata;
  assign bus.tx_valid      = cnt_q != '0;
  assign bus.tx_data       = (cnt_q != '0) ? fifo_q[rd_q] : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      stcnt_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      stcnt_q <= stcnt_d;
    end
  // storage is never cleared; reset only blocks writes
  always_ff @(posedge clk or negedge reset_n)
    if (reset_n) begin
      if (ram_we) ram_q[idx] <= bus.data_to_mem;
      if (push) fifo_q[wr_q] <= bus.data_to_mem;
`ifdef DMEM_STORE_TRACE_EN
      if (ram_we | push) $display("Store [%08h]: %08h", a, bus.data_to_mem);
`else
`endif
    end
endmodule
